fft_buf_ctrl: RTL and testbench

FFT_BUF_CTRL -- requirements
Module: fft_buf_ctrl

---
 rtl/fft_buf_ctrl_pkg.sv | 26 ++
 rtl/fft_buf_ctrl_rd_addr_gen.sv | 47 ++++
 rtl/fft_buf_ctrl.sv | 117 +++++++++++
 tb/tb_fft_buf_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/fft_buf_ctrl_pkg.sv
// Shared FFT buffer parameters and helpers.
//   ADDR_Width  : half-buffer address width (32-point half buffer); common to
//                 the RAM, the core and this controller, never overridden
//   NB_DEFAULT  : default real/imaginary sample width
//   state_t     : buffer controller states
//   bit_reverse : ADDR_Width-bit bit reversal used for natural-order readout
package fft_buf_ctrl_pkg;

    localparam int ADDR_Width = 5;
    localparam int NB_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE,    // no frame in progress, no writes
        ST_WRITE,   // first half filling, nothing to read yet
        ST_STREAM   // writing frame k+1 while reading frame k
    } state_t;

    function automatic logic [ADDR_Width-1:0] bit_reverse(input logic [ADDR_Width-1:0] a);
        logic [ADDR_Width-1:0] r;
        r = '0;
        for (int i = 0; i < ADDR_Width; i++)
            r[i] = a[ADDR_Width-1-i];
        return r;
    endfunction

endpackage

// File: rtl/fft_buf_ctrl_rd_addr_gen.sv
// fft_rd_addr_gen: read counter plus read-address mapping for the ping-pong
// FFT buffer.
//   clk, rst : clock, synchronous active-high reset
//   ed       : clock enable, counter holds when low
//   clr      : frame restart, counter back to 0
//   load     : write counter wrapping, counter back to 0 for the new read frame
//   run      : controller is streaming, counter advances each enabled cycle
//   addr     : RAM read address, map(rc)
//   first    : rc is at word 0 of the frame
// Config macro FFT_BITREV_EN: map(rc) is the bit reversal of rc; otherwise
// map(rc) = rc.
module fft_rd_addr_gen
    import fft_buf_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ed,
    input  logic                  clr,
    input  logic                  load,
    input  logic                  run,
    output logic [ADDR_Width-1:0] addr,
    output logic                  first
);

    logic [ADDR_Width-1:0] rc;

    always_ff @(posedge clk) begin
        if (rst)
            rc <= '0;
        else if (ed) begin
            if (clr || load)
                rc <= '0;
            else if (run)
                rc <= rc + 1'b1;
        end
    end

    // addr is a pure function of a register, so it behaves as a registered output
`ifdef FFT_BITREV_EN
    assign addr = bit_reverse(rc);
`else
    assign addr = rc;
`endif

    assign first = (rc == '0);

endmodule

// File: rtl/fft_buf_ctrl.sv
// fft_buf_ctrl: ping-pong input buffer controller for a streaming FFT.
// Writes one sample per enabled cycle into half ~ODD while reading the
// previously filled half ODD back through fft_rd_addr_gen.
//   CLK, RST     : clock, synchronous active-high reset (wins over START)
//   ED           : clock enable, every register holds when low
//   START        : frame start / abort strobe
//   DR, DI       : input sample (real, imaginary)
//   WE, ADDRW    : RAM write enable and write address
//   DRO, DIO     : registered sample, aligned with WE/ADDRW
//   ODD          : half select, write half ~ODD, read half ODD
//   ADDRR        : RAM read address
//   RDY          : pulse with RAM output word 0 of each frame
//   VLD          : RAM output carries valid frame data
// Config macro FFT_BITREV_EN (in fft_rd_addr_gen): bit-reversed read order.
module fft_buf_ctrl
    import fft_buf_ctrl_pkg::*;
#(
    parameter int nb = NB_DEFAULT
)(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ED,
    input  logic                  START,
    input  logic [nb-1:0]         DR,
    input  logic [nb-1:0]         DI,
    output logic                  WE,
    output logic                  ODD,
    output logic [ADDR_Width-1:0] ADDRW,
    output logic [ADDR_Width-1:0] ADDRR,
    output logic [nb-1:0]         DRO,
    output logic [nb-1:0]         DIO,
    output logic                  RDY,
    output logic                  VLD
);

    localparam logic [ADDR_Width-1:0] WC_MAX = '1;

    state_t                state_q, state_d;
    logic [ADDR_Width-1:0] wc;
    logic                  wrap;      // wc wraps at this edge: swap halves
    logic                  writing;   // a sample is captured at this edge
    logic                  streaming;
    logic                  rd_first;

    // next state and per-cycle controls
    always_comb begin
        state_d   = state_q;
        wrap      = 1'b0;
        writing   = 1'b0;
        streaming = 1'b0;
        if (START) begin
            state_d = ST_WRITE;
            writing = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_WRITE: begin
                    writing = 1'b1;
                    wrap    = (wc == WC_MAX);
                    if (wrap)
                        state_d = ST_STREAM;
                end
                ST_STREAM: begin
                    writing   = 1'b1;
                    streaming = 1'b1;
                    wrap      = (wc == WC_MAX);
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            wc      <= '0;
            ODD     <= 1'b0;
            WE      <= 1'b0;
            DRO     <= '0;
            DIO     <= '0;
            RDY     <= 1'b0;
            VLD     <= 1'b0;
        end else if (ED) begin
            state_q <= state_d;
            WE      <= writing;
            if (writing) begin
                DRO <= DR;
                DIO <= DI;
            end
            if (START) begin
                wc  <= '0;
                ODD <= 1'b0;
            end else if (state_q != ST_IDLE) begin
                wc <= wc + 1'b1;
                if (wrap)
                    ODD <= ~ODD;
            end
            // RAM read data lags ADDRR by one cycle; a START drops the read frame
            VLD <= streaming;
            RDY <= streaming && rd_first;
        end
    end

    assign ADDRW = wc;

    fft_rd_addr_gen u_rd_addr_gen (
        .clk   (CLK),
        .rst   (RST),
        .ed    (ED),
        .clr   (START),
        .load  (wrap),
        .run   (streaming),
        .addr  (ADDRR),
        .first (rd_first)
    );

endmodule

// File: tb/tb_fft_buf_ctrl.sv
// tb_fft_buf_ctrl: directed self-checking bench for fft_buf_ctrl.
// Cycle k is the cycle after the k-th enabled edge following the START
// cycle (cycle 0); outputs are sampled 1 time unit after each rising edge.
// Follows FFT_BITREV_EN for the expected read order.
module tb_fft_buf_ctrl;

    localparam int NB = 16;

    logic          CLK = 1'b0;
    logic          RST, ED, START;
    logic [NB-1:0] DR, DI;
    logic          WE, ODD, RDY, VLD;
    logic [4:0]    ADDRW, ADDRR;
    logic [NB-1:0] DRO, DIO;

    int n_cmp = 0;
    int n_err = 0;

    fft_buf_ctrl #(.nb(NB)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .ED    (ED),
        .START (START),
        .DR    (DR),
        .DI    (DI),
        .WE    (WE),
        .ODD   (ODD),
        .ADDRW (ADDRW),
        .ADDRR (ADDRR),
        .DRO   (DRO),
        .DIO   (DIO),
        .RDY   (RDY),
        .VLD   (VLD)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // expected read address for read word n
    function automatic logic [4:0] rmap(input int n);
        logic [4:0] a;
        a = n[4:0];
`ifdef FFT_BITREV_EN
        return {a[0], a[1], a[2], a[3], a[4]};
`else
        return a;
`endif
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, ".we"},    WE,    0);
        chk({tag, ".odd"},   ODD,   0);
        chk({tag, ".addrw"}, ADDRW, 0);
        chk({tag, ".addrr"}, ADDRR, 0);
        chk({tag, ".dro"},   DRO,   0);
        chk({tag, ".dio"},   DIO,   0);
        chk({tag, ".rdy"},   RDY,   0);
        chk({tag, ".vld"},   VLD,   0);
    endtask

    initial begin
        int k;
        RST = 1'b1; ED = 1'b0; START = 1'b0; DR = '0; DI = '0;

        // reset acts with ED low
        tick(); tick();
        chk_all_zero("rst");

        // two frames back to back: fill, swap, read out
        RST = 1'b0; ED = 1'b1;
        for (int c = 0; c < 70; c++) begin
            START = (c == 0);
            DR    = NB'(c);
            DI    = NB'(1000 + c);
            tick();
            k = c + 1;
            chk("fill.we",    WE,    1);
            chk("fill.addrw", ADDRW, (k - 1) % 32);
            chk("fill.dro",   DRO,   k - 1);
            chk("fill.dio",   DIO,   1000 + k - 1);
            chk("fill.odd",   ODD,   ((k - 1) / 32) % 2);
            chk("fill.rdy",   RDY,   (k == 34 || k == 66));
            chk("fill.vld",   VLD,   (k >= 34));
            if (k >= 33)
                chk("fill.addrr", ADDRR, rmap((k - 33) % 32));
        end

        // restart while streaming, then abort again at sample 20 of frame 2
        for (int c = 0; c < 90; c++) begin
            START = (c == 0 || c == 52);
            DR    = NB'(c);
            DI    = NB'(c);
            tick();
            k = c + 1;
            chk("abort.rdy", RDY, (k == 34 || k == 86));
            chk("abort.vld", VLD, (k >= 34 && k <= 52) || k >= 86);
            if (k >= 53) begin
                chk("abort.addrw", ADDRW, (k - 53) % 32);
                chk("abort.odd",   ODD,   ((k - 53) / 32) % 2);
            end
        end
        START = 1'b0;

        // ED toggling: START/DR during ED low must be ignored
        for (int i = 0; i < 40; i++) begin
            ED = 1'b1; START = (i == 0); DR = NB'(500 + i);
            tick();
            chk("ed.we",    WE,    1);
            chk("ed.addrw", ADDRW, i % 32);
            chk("ed.dro",   DRO,   500 + i);
            chk("ed.odd",   ODD,   (i >= 32));
            chk("ed.rdy",   RDY,   (i == 33));
            chk("ed.vld",   VLD,   (i >= 33));
            ED = 1'b0; START = 1'b1; DR = NB'(999);
            tick();
            chk("ed_hold.addrw", ADDRW, i % 32);
            chk("ed_hold.dro",   DRO,   500 + i);
            chk("ed_hold.odd",   ODD,   (i >= 32));
            chk("ed_hold.rdy",   RDY,   (i == 33));
            chk("ed_hold.vld",   VLD,   (i >= 33));
        end
        ED = 1'b1; START = 1'b0;

        // reset together with START mid-frame
        for (int c = 0; c < 10; c++) begin
            START = (c == 0); DR = NB'(c + 1); DI = NB'(c + 1);
            tick();
        end
        chk("pre_rst.addrw", ADDRW, 9);
        RST = 1'b1; START = 1'b1; DR = NB'(77); DI = NB'(77);
        tick();
        chk_all_zero("rst_start");
        RST = 1'b0; START = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            chk("idle.we",  WE,  0);
            chk("idle.vld", VLD, 0);
            chk("idle.rdy", RDY, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
